ps2_tx: RTL and testbench

PS2_TX -- requirements
Module: ps2_tx

---
 rtl/ps2_tx.sv | 171 +++++++++++++++++
 tb/tb_ps2_tx.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Optional watchdog on device clock edges enabled by defining PS2_TX_TIMEOUT_EN.
`timescale 1ns/1ps
module ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 2518,
  parameter int unsigned TIMEOUT_CYCLES = 50350
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2clk_in,
  input  logic       ps2dat_in,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle, StInhibit, StStart, StData, StAck, StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic            parity_q, parity_d;
  logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic            dat_oe_q, dat_oe_d;
  logic            clk_meta_q, clk_sync_q, clk_prev_q;
  logic            dat_meta_q, dat_sync_q;
  logic            fall, done_raw, err_raw;

  assign fall = clk_prev_q & ~clk_sync_q;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           timing, timed_out;

  assign timing    = state_q inside {StData, StAck, StWaitIdle};
  assign timed_out = timing && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));

  // Restarts on every device edge; held at zero outside the device-clocked states.
  always_comb begin
    to_cnt_d = '0;
    if (timing && !fall) to_cnt_d = to_cnt_q + ToW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  // Parameter kept so both builds share one interface.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    parity_d  = parity_q;
    inh_cnt_d = inh_cnt_q;
    bit_idx_d = bit_idx_q;
    dat_oe_d  = dat_oe_q;
    ps2clk_oe = 1'b0;
    done_raw  = 1'b0;
    err_raw   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tx_valid) begin
          data_d    = tx_data;
          parity_d  = ~^tx_data;
          inh_cnt_d = '0;
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        ps2clk_oe = 1'b1;
        if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
          dat_oe_d = 1'b1;
          state_d  = StStart;
        end else begin
          inh_cnt_d = inh_cnt_q + InhW'(1);
        end
      end
      StStart: begin
        ps2clk_oe = 1'b1;
        inh_cnt_d = '0;
        bit_idx_d = '0;
        state_d   = StData;
      end
      StData: begin
        if (fall) begin
          // Edges 1..8 data LSB first, 9 parity, 10 stop (release).
          if (bit_idx_q < 4'd8)       dat_oe_d = ~data_q[bit_idx_q[2:0]];
          else if (bit_idx_q == 4'd8) dat_oe_d = ~parity_q;
          else                        dat_oe_d = 1'b0;
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd9) state_d = StAck;
        end
      end
      StAck: begin
        if (fall) begin
          if (dat_sync_q) begin
            err_raw = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StWaitIdle;
          end
        end
      end
      StWaitIdle: begin
        if (clk_sync_q && dat_sync_q) begin
          done_raw = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    if (timed_out && !done_raw) begin
      err_raw = 1'b1;
      state_d = StIdle;
    end
`endif
    if (state_d == StIdle) dat_oe_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      data_q     <= '0;
      parity_q   <= 1'b0;
      inh_cnt_q  <= '0;
      bit_idx_q  <= '0;
      dat_oe_q   <= 1'b0;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      inh_cnt_q  <= inh_cnt_d;
      bit_idx_q  <= bit_idx_d;
      dat_oe_q   <= dat_oe_d;
      clk_meta_q <= ps2clk_in;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2dat_in;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign tx_ready  = (state_q == StIdle);
  assign busy      = ~tx_ready;
  assign ps2dat_oe = dat_oe_q;
  // A reset cycle must never leak a completion pulse.
  assign done      = done_raw & ~reset;
  assign error     = err_raw & ~reset;

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: device model, bit scoreboard, handshake and timeout checks.
`timescale 1ns/1ps
module tb_ps2_tx;
  localparam int H       = 10;
  localparam int INHIBIT = 2518;
  localparam int TIMEOUT = 50350;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready, ps2clk_oe, ps2dat_oe, busy, done, error;
  logic       dev_clk  = 1'b1;
  logic       dev_dat  = 1'b1;
  logic       ps2clk_in, ps2dat_in;

  int n_checks = 0, n_fail = 0;
  int done_cnt = 0, err_cnt = 0, idle_oe_viol = 0, overlap = 0;
  logic exp_bits[$];

  // Open-collector lines: low if either side pulls.
  assign ps2clk_in = dev_clk & ~ps2clk_oe;
  assign ps2dat_in = dev_dat & ~ps2dat_oe;

  ps2_tx dut (
    .clk       (clk),
    .reset     (reset),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .ps2clk_in (ps2clk_in),
    .ps2dat_in (ps2dat_in),
    .ps2clk_oe (ps2clk_oe),
    .ps2dat_oe (ps2dat_oe),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (error) err_cnt <= err_cnt + 1;
    if (done && error) overlap <= overlap + 1;
    if (tx_ready && (ps2clk_oe || ps2dat_oe)) idle_oe_viol <= idle_oe_viol + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic pop_exp();
    if (exp_bits.size() == 0) return 1'bx;
    return exp_bits.pop_front();
  endfunction

  // Frame as seen on the data pin: start, d0..d7, odd parity, stop.
  task automatic push_frame(input logic [7:0] d);
    int ones = 0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    exp_bits.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
    exp_bits.push_back(1'b1);
  endtask

  task automatic offer(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic handshake();
    int inh = 0;
    @(negedge clk);
    while (ps2clk_oe && !ps2dat_oe && inh < INHIBIT + 500) begin
      inh++;
      @(negedge clk);
    end
    n_checks++;
    if (inh !== INHIBIT) begin
      n_fail++;
      $display("FAIL inhibit_len: got %0d cycles, expected %0d", inh, INHIBIT);
    end
    n_checks++;
    if (!(ps2clk_oe === 1'b1 && ps2dat_oe === 1'b1)) begin
      n_fail++;
      $display("FAIL start_overlap: clk_oe=%b dat_oe=%b, expected 1 1", ps2clk_oe, ps2dat_oe);
    end
    @(negedge clk);
    n_checks++;
    if (ps2clk_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL clk_release: clk_oe=%b, expected 0", ps2clk_oe);
    end
  endtask

  task automatic device(input int n_edges, input logic ack);
    logic exp_b;
    exp_b = pop_exp();
    n_checks++;
    if (ps2dat_in !== exp_b) begin
      n_fail++;
      $display("FAIL start_bit: pin=%b expected=%b", ps2dat_in, exp_b);
    end
    repeat (H) @(posedge clk);
    for (int e = 1; e <= n_edges; e++) begin
      @(posedge clk);
      #1 dev_clk = 1'b0;
      repeat (H) @(posedge clk);
      #1 dev_clk = 1'b1;
      repeat (H) @(negedge clk);
      if (e <= 10) begin
        exp_b = pop_exp();
        n_checks++;
        if (ps2dat_in !== exp_b) begin
          n_fail++;
          $display("FAIL frame_bit%0d: pin=%b expected=%b", e, ps2dat_in, exp_b);
        end
      end
      if (e == 10) begin
        dev_dat = ack;
        repeat (4) @(negedge clk);
      end
    end
    if (n_edges == 11) dev_dat = 1'b1;
  endtask

  task automatic wait_result(input int d0, input int e0);
    int k = 0;
    while (done_cnt == d0 && err_cnt == e0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_tx_ready: %b expected 1", tx_ready); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: %b expected 0", busy); end
    n_checks++;
    if (ps2clk_oe !== 1'b0 || ps2dat_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_oe: clk_oe=%b dat_oe=%b expected 0 0", ps2clk_oe, ps2dat_oe);
    end
    n_checks++;
    if (done !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_pulses: done=%b error=%b expected 0 0", done, error);
    end
  endtask

  task automatic test_transfer(input logic [7:0] d);
    int d0 = done_cnt, e0 = err_cnt;
    push_frame(d);
    offer(d);
    handshake();
    device(11, 1'b0);
    wait_result(d0, e0);
    n_checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      n_fail++;
      $display("FAIL xfer_%h_result: done=%0d error=%0d expected 1 0", d, done_cnt - d0,
               err_cnt - e0);
    end
    n_checks++;
    if (tx_ready !== 1'b1 || ps2clk_oe !== 1'b0 || ps2dat_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL xfer_%h_idle: ready=%b clk_oe=%b dat_oe=%b expected 1 0 0", d, tx_ready,
               ps2clk_oe, ps2dat_oe);
    end
  endtask

  task automatic test_nack();
    int d0 = done_cnt, e0 = err_cnt;
    push_frame(8'hFF);
    offer(8'hFF);
    handshake();
    device(11, 1'b1);
    wait_result(d0, e0);
    n_checks++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
      n_fail++;
      $display("FAIL nack_result: error=%0d done=%0d expected 1 0", err_cnt - e0, done_cnt - d0);
    end
    n_checks++;
    if (ps2clk_oe !== 1'b0 || ps2dat_oe !== 1'b0 || tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL nack_idle: clk_oe=%b dat_oe=%b ready=%b expected 0 0 1", ps2clk_oe,
               ps2dat_oe, tx_ready);
    end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt, e0 = err_cnt;
    int starts = 0;
    push_frame(8'h3C);
    offer(8'h3C);
    handshake();
    @(negedge clk);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    n_checks++;
    if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready: %b expected 0", tx_ready); end
    @(posedge clk);
    #1 tx_valid = 1'b0;
    device(11, 1'b0);
    wait_result(d0, e0);
    repeat (30) begin
      @(negedge clk);
      if (ps2clk_oe) starts++;
    end
    n_checks++;
    if (starts !== 0) begin
      n_fail++;
      $display("FAIL ignored_valid: clk_oe seen %0d cycles, expected 0", starts);
    end
    push_frame(8'h81);
    offer(8'h81);
    handshake();
    device(11, 1'b0);
    wait_result(d0 + 1, e0);
    n_checks++;
    if (done_cnt - d0 !== 2 || err_cnt - e0 !== 0) begin
      n_fail++;
      $display("FAIL b2b_result: done=%0d error=%0d expected 2 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_timeout();
    int d0 = done_cnt, e0 = err_cnt;
    push_frame(8'h5A);
    offer(8'h5A);
    handshake();
    device(3, 1'b1);
    exp_bits.delete();
    @(posedge clk);
    #1 dev_clk = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    begin
      int n = 0;
      while (n < TIMEOUT + 100) begin
        @(posedge clk);
        n++;
        if (n == H) #1 dev_clk = 1'b1;
        @(negedge clk);
        if (error) break;
      end
      // Two synchronizer stages sit between the pin and the detected edge.
      n_checks++;
      if (n !== TIMEOUT + 2) begin
        n_fail++;
        $display("FAIL timeout_len: error after %0d cycles, expected %0d", n, TIMEOUT + 2);
      end
      @(negedge clk);
      n_checks++;
      if (ps2clk_oe !== 1'b0 || ps2dat_oe !== 1'b0 || tx_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL timeout_idle: clk_oe=%b dat_oe=%b ready=%b expected 0 0 1", ps2clk_oe,
                 ps2dat_oe, tx_ready);
      end
      n_checks++;
      if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
        n_fail++;
        $display("FAIL timeout_pulses: error=%0d done=%0d expected 1 0", err_cnt - e0,
                 done_cnt - d0);
      end
    end
`else
    repeat (H) @(posedge clk);
    #1 dev_clk = 1'b1;
    repeat (3000) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || ps2clk_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_state: busy=%b clk_oe=%b expected 1 0", busy, ps2clk_oe);
    end
    n_checks++;
    if (err_cnt - e0 !== 0 || done_cnt - d0 !== 0) begin
      n_fail++;
      $display("FAIL stall_pulses: error=%0d done=%0d expected 0 0", err_cnt - e0,
               done_cnt - d0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt, e0 = err_cnt;
    push_frame(8'hA5);
    offer(8'hA5);
    handshake();
    device(5, 1'b1);
    n_checks++;
    if (ps2dat_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_dat_oe: %b expected 1 before reset", ps2dat_oe);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ps2clk_oe !== 1'b0 || ps2dat_oe !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: clk_oe=%b dat_oe=%b ready=%b busy=%b expected 0 0 1 0",
               ps2clk_oe, ps2dat_oe, tx_ready, busy);
    end
    exp_bits.delete();
    repeat (50) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
      n_fail++;
      $display("FAIL mid_pulses: done=%0d error=%0d expected 0 0", done_cnt - d0, err_cnt - e0);
    end
    test_transfer(8'h00);
  endtask

  initial begin
    test_reset();
    test_transfer(8'hED);
    test_transfer(8'hF4);
    test_nack();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    n_checks++;
    if (idle_oe_viol !== 0) begin
      n_fail++;
      $display("FAIL idle_oe: %0d cycles with oe in idle, expected 0", idle_oe_viol);
    end
    n_checks++;
    if (overlap !== 0) begin
      n_fail++;
      $display("FAIL done_error_overlap: %0d cycles, expected 0", overlap);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
